// File: rtl/pw_pkg.sv
// Shared types and constants for the keypad password lock.
// Optional build macro PW_CHANGE_EN (used by pw_entry_ctrl) enables
// changing the stored password while the lock is open.
package pw_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        CHECK,
        OPEN,
        LOCKOUT
    } pw_state_t;

    localparam int         DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    // True for a keypad code that is a real decimal digit.
    function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/pw_lockout_timer.sv
// Lockout down-counter: load with LOCK_CYCLES-1, count down to zero and hold.
// The zero flag tells the controller the final lockout cycle has arrived.
module pw_lockout_timer #(
    parameter int LOCK_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int            TW       = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [TW-1:0] LOAD_VAL = TW'(LOCK_CYCLES - 1);

    logic [TW-1:0] cnt_q;

    // Load takes precedence; decrement stops at zero so the flag stays asserted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= LOAD_VAL;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - TW'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pw_entry_ctrl.sv
// Keypad password lock sequencer: collects BCD digits into an entry word,
// compares on enter, opens the lock or counts failures, and enforces a timed
// lockout after MAX_FAIL consecutive failures.
// Optional build macro PW_CHANGE_EN: while OPEN, a full-length entry followed
// by enter replaces the stored password. Without it the password is the
// constant DEFAULT_PW and keys are ignored while OPEN.
// Status outputs are registered from the current state, so they trail the
// state register by one cycle (enter -> CHECK -> unlock/fail_pulse visible
// two edges after enter is sampled).
module pw_entry_ctrl
    import pw_pkg::*;
#(
    parameter int                   DIGITS      = 4,
    parameter int                   MAX_FAIL    = 5,
    parameter int                   LOCK_CYCLES = 1000,
    parameter logic [4*DIGITS-1:0]  DEFAULT_PW  = 16'h1234
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         key_valid,
    input  logic [3:0]                   key_digit,
    input  logic                         key_enter,
    input  logic                         key_clear,
    input  logic                         relock,
    output logic                         unlock,
    output logic                         lockout,
    output logic                         fail_pulse,
    output logic [$clog2(DIGITS+1)-1:0]  entry_cnt,
    output logic [3:0]                   fail_cnt
);

    localparam int               PW_W       = DIGITS * DIGIT_W;
    localparam int               CNT_W      = $clog2(DIGITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DIGITS);
    localparam logic [3:0]       FAIL_LIMIT = 4'(MAX_FAIL);

    pw_state_t       state_q, state_d;
    logic [PW_W-1:0] buf_q;
    logic [PW_W-1:0] pw;
    logic            digit_ok;
    logic            match;
    logic            buf_shift, buf_clr;
    logic            fail_inc, fail_clr;
    logic            tmr_load, tmr_dec, tmr_zero;
    logic            chk_fail, chk_fail_q;
`ifdef PW_CHANGE_EN
    logic            pw_load;
    logic [PW_W-1:0] pw_q;
`endif

    // Failure counter increment that sticks at MAX_FAIL instead of wrapping.
    function automatic logic [3:0] fail_sat_inc(input logic [3:0] c);
        return (c < FAIL_LIMIT) ? c + 4'd1 : c;
    endfunction

    // A digit is accepted only if it is BCD and the buffer still has room.
    assign digit_ok = key_valid && is_bcd(key_digit) && (entry_cnt != CNT_FULL);
    assign match    = (entry_cnt == CNT_FULL) && (buf_q == pw);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control; clear beats enter beats a new digit.
    always_comb begin
        state_d   = state_q;
        buf_shift = 1'b0;
        buf_clr   = 1'b0;
        fail_inc  = 1'b0;
        fail_clr  = 1'b0;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;
        chk_fail  = 1'b0;
`ifdef PW_CHANGE_EN
        pw_load   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (key_clear) begin
                    buf_clr = 1'b1;
                end else if (key_enter) begin
                    state_d = CHECK;
                end else if (digit_ok) begin
                    buf_shift = 1'b1;
                    state_d   = ENTRY;
                end
            end
            ENTRY: begin
                if (key_clear) begin
                    buf_clr = 1'b1;
                    state_d = IDLE;
                end else if (key_enter) begin
                    state_d = CHECK;
                end else if (digit_ok) begin
                    buf_shift = 1'b1;
                end
            end
            CHECK: begin
                buf_clr = 1'b1;
                if (match) begin
                    fail_clr = 1'b1;
                    state_d  = OPEN;
                end else begin
                    chk_fail = 1'b1;
                    fail_inc = 1'b1;
                    if (fail_sat_inc(fail_cnt) == FAIL_LIMIT) begin
                        tmr_load = 1'b1;
                        state_d  = LOCKOUT;
                    end else begin
                        state_d  = IDLE;
                    end
                end
            end
            OPEN: begin
                if (relock) begin
                    buf_clr = 1'b1;
                    state_d = IDLE;
                end
`ifdef PW_CHANGE_EN
                else if (key_clear) begin
                    buf_clr = 1'b1;
                end else if (key_enter) begin
                    buf_clr = 1'b1;
                    pw_load = (entry_cnt == CNT_FULL);
                end else if (digit_ok) begin
                    buf_shift = 1'b1;
                end
`endif
            end
            LOCKOUT: begin
                if (tmr_zero) begin
                    fail_clr = 1'b1;
                    state_d  = IDLE;
                end else begin
                    tmr_dec  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Entry buffer: new digit enters the LS nibble, older digits move left.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q     <= '0;
            entry_cnt <= '0;
        end else if (buf_clr) begin
            buf_q     <= '0;
            entry_cnt <= '0;
        end else if (buf_shift) begin
            buf_q     <= (buf_q << DIGIT_W) | PW_W'(key_digit);
            entry_cnt <= entry_cnt + CNT_W'(1);
        end
    end

    // Consecutive failure counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fail_cnt <= 4'd0;
        end else if (fail_clr) begin
            fail_cnt <= 4'd0;
        end else if (fail_inc) begin
            fail_cnt <= fail_sat_inc(fail_cnt);
        end
    end

`ifdef PW_CHANGE_EN
    // Stored password, replaced by a complete entry submitted while open.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pw_q <= DEFAULT_PW;
        end else if (pw_load) begin
            pw_q <= buf_q;
        end
    end

    assign pw = pw_q;
`else
    assign pw = DEFAULT_PW;
`endif

    // Registered status outputs; fail_pulse is delayed to line up with unlock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            unlock     <= 1'b0;
            lockout    <= 1'b0;
            chk_fail_q <= 1'b0;
            fail_pulse <= 1'b0;
        end else begin
            unlock     <= (state_q == OPEN);
            lockout    <= (state_q == LOCKOUT);
            chk_fail_q <= chk_fail;
            fail_pulse <= chk_fail_q;
        end
    end

    pw_lockout_timer #(
        .LOCK_CYCLES(LOCK_CYCLES)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (tmr_load),
        .dec   (tmr_dec),
        .zero  (tmr_zero)
    );

endmodule
